unified_mem: RTL and testbench
==============================

UNIFIED_MEM -- requirements
Module: unified_mem

Interface
REQ-001 Parameter LATENCY, default 4, access cycles spent in BUSY per transaction (legal 1..15).
REQ-002 Parameter ADDR_W, default 14, line-address width (16-bit word address, 4 words per line).
REQ-003 Parameter LINE_W, default 64, line width in bits (4 x 16-bit words).
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Ports i_addr input ADDR_W, i_rd input 1  instruction-cache fill request (read-only port).
REQ-007 Port i_rdy  output 1  one-cycle pulse, i_rdata valid.
REQ-008 Port i_rdata  output LINE_W  instruction line returned.
REQ-009 Ports d_addr input ADDR_W, d_rd input 1, d_wr input 1, d_wdata input LINE_W  data-cache fill/write-back request.
REQ-010 Port d_rdy  output 1  one-cycle pulse, d_rdata valid / write committed.
REQ-011 Port d_rdata  output LINE_W  data line returned.

Function
REQ-012 Storage SHALL be 2**ADDR_W lines of LINE_W bits, shared by both ports.
REQ-013 FSM SHALL have states IDLE, BUSY, DONE.
REQ-014 In IDLE, an edge seeing any request SHALL grant one port, latch its addr/rd/wr/wdata, load counter with LATENCY-1, and enter BUSY.
REQ-015 In BUSY, counter SHALL decrement each edge; the edge at counter 0 SHALL perform the access and enter DONE.
REQ-016 On entering DONE, the granted port's rdy SHALL be high for exactly one cycle with rdata valid; the next edge SHALL return to IDLE.
REQ-017 Latency: request sampled at edge N -> rdy high in the cycle after edge N+LATENCY, low after edge N+LATENCY+1.
REQ-018 The ungranted port's rdy and rdata SHALL not change while the other port is served.
REQ-019 Requestor SHALL hold its request until rdy; inputs after the grant edge SHALL be ignored (latched copy used).
REQ-020 A request dropped before rdy SHALL still complete; rdy still pulses.
REQ-021 d_rd and d_wr both high SHALL perform the write only; d_rdata returns d_wdata.
REQ-022 A write SHALL commit to storage on the same edge that raises d_rdy.
REQ-023 A read of a line written by an earlier completed transaction SHALL return the new value.
REQ-024 Back-to-back: a request held through DONE SHALL be sampled on the first IDLE edge; one transaction per LATENCY+2 edges.
REQ-025 Simultaneous i_rd and d_rd/d_wr in IDLE SHALL be arbitrated per REQ-029/REQ-030.
REQ-026 Address wrap: addr is a line index; no wrap beyond 2**ADDR_W-1 exists.

Reset
REQ-027 rst_n low SHALL force state IDLE, counter 0, i_rdy 0, d_rdy 0, i_rdata 0, d_rdata 0, arbitration pointer to D port.
REQ-028 Reset mid-transaction SHALL abort it; an uncommitted write SHALL not reach storage; storage contents SHALL be unaffected by reset.

Configuration
REQ-029 Macro UNIFIED_MEM_RR_ARB_EN defined: round-robin, pointer flips to the other port after every grant; contention grants the pointed port.
REQ-030 Macro undefined: fixed priority, D port always wins contention; I port served only when D idle.

Structure
REQ-031 Package mem_pkg SHALL hold LINE_W, ADDR_W defaults, FSM state enum, port index constants (PORT_I, PORT_D).
REQ-032 Arbitration SHALL be a sub-module mem_arb (two requests, pointer, one-hot grant), containing the UNIFIED_MEM_RR_ARB_EN switch.

Verification
REQ-033 Reset, then i_rd=1, i_addr=0x0010 at edge 0 (LATENCY=4) -> i_rdy high only in cycle after edge 4, i_rdata = preloaded line 0x0010.
REQ-034 d_wr=1, d_addr=0x0123, d_wdata=0xDEAD_BEEF_0123_4567 -> d_rdy pulse; then d_rd same addr -> d_rdata=0xDEAD_BEEF_0123_4567.
REQ-035 i_rd and d_rd both asserted at one edge, held -> without macro D served then I; with UNIFIED_MEM_RR_ARB_EN, D then I, and next contention I first.
REQ-036 d_wr to 0x0040 with rst_n pulled low at BUSY counter 1 -> no d_rdy; later read of 0x0040 returns prior contents.
REQ-037 d_rd and d_wr both high, d_wdata=0x1111_2222_3333_4444 -> d_rdata equals write data, storage updated.
REQ-038 i_rd dropped one edge after grant -> i_rdy still pulses at edge N+4, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the unified instruction/data line memory.
// Holds default geometry, FSM state encoding and arbiter port indices.
package mem_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_LINE_W = 64;

    // Bit positions inside the one-hot grant vector.
    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb.sv
// Two-port arbiter for unified_mem (I fetch vs D fill/write-back); one-hot grant.
// Latency: combinational grant, pointer updates on the edge a grant is taken.
// Backpressure: grants only while en is high; losing request must be held by requestor.
// UNIFIED_MEM_RR_ARB_EN selects round-robin; otherwise the D port wins every contention.
module mem_arb
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req_i,
    input  logic       req_d,
    output logic [1:0] gnt
);

    // High means the next contention goes to the D port.
    logic ptr_d;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req_d && (!req_i || ptr_d)) begin
                gnt[PORT_D] = 1'b1;
            end else if (req_i) begin
                gnt[PORT_I] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_d <= 1'b1;
        end else if (|gnt) begin
`ifdef UNIFIED_MEM_RR_ARB_EN
            ptr_d <= gnt[PORT_I];
`else
            ptr_d <= 1'b1;
`endif
        end
    end

endmodule

// File: rtl/unified_mem.sv
// Shared line memory serving an I-cache fill port and a D-cache fill/write-back port.
// Latency: request sampled at edge N, rdy pulses in the cycle after edge N+LATENCY.
// Backpressure: one transaction at a time; requestor holds its request until its rdy pulse.
// Arbitration policy chosen by UNIFIED_MEM_RR_ARB_EN (see mem_arb).
module unified_mem
    import mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LINE_W  = MEM_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic              i_rdy,
    output logic [LINE_W-1:0] i_rdata,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [LINE_W-1:0] d_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [1:0]        gnt;
    logic              arb_en;
    logic              d_req;
    logic              access;
    logic              sel_d;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;

    assign arb_en = (state == ST_IDLE);
    assign d_req  = d_rd | d_wr;
    assign access = (state == ST_BUSY) && (cnt == 4'd0);

    mem_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req_i (i_rd),
        .req_d (d_req),
        .gnt   (gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|gnt) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured at grant so the requestor may change or drop them afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            sel_d     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            i_rdy     <= 1'b0;
            d_rdy     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nxt;
            i_rdy <= 1'b0;
            d_rdy <= 1'b0;
            if (state == ST_IDLE && |gnt) begin
                cnt       <= CNT_LOAD;
                sel_d     <= gnt[PORT_D];
                lat_wr    <= gnt[PORT_D] & d_wr;
                lat_addr  <= gnt[PORT_D] ? d_addr : i_addr;
                lat_wdata <= d_wdata;
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                if (sel_d) begin
                    d_rdy   <= 1'b1;
                    d_rdata <= lat_wr ? lat_wdata : mem[lat_addr];
                end else begin
                    i_rdy   <= 1'b1;
                    i_rdata <= mem[lat_addr];
                end
            end
        end
    end

    // Storage has no reset; a reset before the access edge leaves it untouched.
    always_ff @(posedge clk) begin
        if (access && sel_d && lat_wr) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Randomized self-checking bench for unified_mem against a line-array reference model.
module tb_unified_mem;

    localparam int LAT = 4;
    localparam int AW  = 14;
    localparam int LW  = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_addr;
    logic          i_rd;
    logic          i_rdy;
    logic [LW-1:0] i_rdata;
    logic [AW-1:0] d_addr;
    logic          d_rd;
    logic          d_wr;
    logic [LW-1:0] d_wdata;
    logic          d_rdy;
    logic [LW-1:0] d_rdata;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] mem_m [int];
    bit            ptr_d_m;
    logic [AW-1:0] addrs [8];

    unified_mem #(.LATENCY(LAT), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_addr  (i_addr),
        .i_rd    (i_rd),
        .i_rdy   (i_rdy),
        .i_rdata (i_rdata),
        .d_addr  (d_addr),
        .d_rd    (d_rd),
        .d_wr    (d_wr),
        .d_wdata (d_wdata),
        .d_rdy   (d_rdy),
        .d_rdata (d_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit contention_d_first();
`ifdef UNIFIED_MEM_RR_ARB_EN
        return ptr_d_m;
`else
        return 1'b1;
`endif
    endfunction

    // One uncontended transaction; the DUT is idle when this starts.
    task automatic single_txn(input bit is_d, input bit rd, input bit wr,
                              input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                              input bit drop);
        logic [LW-1:0] exp;
        logic [LW-1:0] other_rdata;
        int            k;
        bit            seen;
        bit            other_rdy_seen;
        if (is_d) begin
            d_addr = addr; d_rd = rd; d_wr = wr; d_wdata = wdata;
        end else begin
            i_addr = addr; i_rd = 1'b1;
        end
        exp         = (is_d && wr) ? wdata : mem_m[int'(addr)];
        other_rdata = is_d ? i_rdata : d_rdata;
        @(posedge clk); #1;
        ptr_d_m = ~is_d;
        // Inputs after the grant edge must be ignored.
        if (is_d) begin
            d_addr  = AW'($urandom);
            d_wdata = {$urandom, $urandom};
            if (drop) begin d_rd = 1'b0; d_wr = 1'b0; end
        end else begin
            i_addr = AW'($urandom);
            if (drop) i_rd = 1'b0;
        end
        seen = 1'b0;
        other_rdy_seen = 1'b0;
        k = 0;
        while (!seen && k < LAT + 4) begin
            @(posedge clk); #1;
            k++;
            seen = is_d ? d_rdy : i_rdy;
            if (is_d ? i_rdy : d_rdy) other_rdy_seen = 1'b1;
        end
        check_eq(is_d ? "d_latency" : "i_latency", seen ? 64'(k) : 64'd0, 64'(LAT));
        check_eq(is_d ? "d_rdata" : "i_rdata", is_d ? d_rdata : i_rdata, exp);
        if (is_d && wr) mem_m[int'(addr)] = wdata;
        d_rd = 1'b0; d_wr = 1'b0; i_rd = 1'b0;
        @(posedge clk); #1;
        check_eq(is_d ? "d_rdy_pulse" : "i_rdy_pulse", is_d ? 64'(d_rdy) : 64'(i_rdy), 64'd0);
        check_eq("other_rdata_stable", is_d ? i_rdata : d_rdata, other_rdata);
        check_eq("other_rdy_quiet", 64'(other_rdy_seen), 64'd0);
    endtask

    // Both ports request reads at the same edge and hold until served.
    task automatic contend(input logic [AW-1:0] ia, input logic [AW-1:0] da);
        bit first_d;
        int k;
        int i_at;
        int d_at;
        first_d = contention_d_first();
        i_addr = ia; i_rd = 1'b1;
        d_addr = da; d_rd = 1'b1; d_wr = 1'b0;
        @(posedge clk); #1;
        k = 0; i_at = 0; d_at = 0;
        while ((i_at == 0 || d_at == 0) && k < 3 * (LAT + 2)) begin
            @(posedge clk); #1;
            k++;
            if (d_rdy) begin
                d_at = k; d_rd = 1'b0;
                check_eq("cont_d_rdata", d_rdata, mem_m[int'(da)]);
            end
            if (i_rdy) begin
                i_at = k; i_rd = 1'b0;
                check_eq("cont_i_rdata", i_rdata, mem_m[int'(ia)]);
            end
        end
        check_eq("cont_d_edge", 64'(d_at), first_d ? 64'(LAT) : 64'(2 * LAT + 2));
        check_eq("cont_i_edge", 64'(i_at), first_d ? 64'(2 * LAT + 2) : 64'(LAT));
        ptr_d_m = first_d;
        @(posedge clk); #1;
        check_eq("cont_rdy_low", {62'd0, i_rdy, d_rdy}, 64'd0);
    endtask

    initial begin
        logic [LW-1:0] old_val;
        bit            mid_rdy;
        rst_n = 1'b0;
        i_addr = '0; i_rd = 1'b0;
        d_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_wdata = '0;
        ptr_d_m = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_i_rdy", 64'(i_rdy), 64'd0);
        check_eq("rst_d_rdy", 64'(d_rdy), 64'd0);
        check_eq("rst_i_rdata", i_rdata, 64'd0);
        check_eq("rst_d_rdata", d_rdata, 64'd0);
        rst_n = 1'b1;

        addrs[0] = 14'h0010; addrs[1] = 14'h0123; addrs[2] = 14'h0040; addrs[3] = 14'h3FFF;
        addrs[4] = 14'h0000; addrs[5] = 14'h1234; addrs[6] = 14'h2001; addrs[7] = 14'h0777;
        foreach (addrs[j]) single_txn(1'b1, 1'b0, 1'b1, addrs[j], {$urandom, $urandom}, 1'b0);

        single_txn(1'b0, 1'b1, 1'b0, 14'h0010, '0, 1'b0);
        single_txn(1'b1, 1'b0, 1'b1, 14'h0123, 64'hDEAD_BEEF_0123_4567, 1'b0);
        single_txn(1'b1, 1'b1, 1'b0, 14'h0123, '0, 1'b0);
        check_eq("write_readback", d_rdata, 64'hDEAD_BEEF_0123_4567);
        single_txn(1'b1, 1'b1, 1'b1, 14'h0123, 64'h1111_2222_3333_4444, 1'b0);
        single_txn(1'b0, 1'b1, 1'b0, 14'h0123, '0, 1'b0);
        single_txn(1'b0, 1'b1, 1'b0, 14'h3FFF, '0, 1'b1);

        contend(14'h0010, 14'h0040);
        single_txn(1'b1, 1'b1, 1'b0, 14'h0777, '0, 1'b0);
        contend(14'h1234, 14'h2001);

        // Abort a write to 0x0040 with the access counter at 1.
        old_val = mem_m[32'h40];
        d_addr = 14'h0040; d_wr = 1'b1; d_rd = 1'b0; d_wdata = ~old_val;
        mid_rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (d_rdy) mid_rdy = 1'b1;
        end
        rst_n = 1'b0;
        d_wr = 1'b0;
        ptr_d_m = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (d_rdy) mid_rdy = 1'b1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (d_rdy) mid_rdy = 1'b1;
        check_eq("abort_no_rdy", 64'(mid_rdy), 64'd0);
        check_eq("abort_d_rdata", d_rdata, 64'd0);
        single_txn(1'b1, 1'b1, 1'b0, 14'h0040, '0, 1'b0);
        check_eq("abort_storage", d_rdata, old_val);

        for (int n = 0; n < 40; n++) begin
            bit            is_d;
            bit            drop;
            int unsigned   sel;
            logic [AW-1:0] a;
            is_d = 1'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            sel  = $urandom_range(1, 3);
            a    = addrs[$urandom_range(0, 7)];
            if (n % 8 == 7) contend(addrs[$urandom_range(0, 7)], a);
            else single_txn(is_d, sel[0], is_d & sel[1], a, {$urandom, $urandom}, drop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
